// File: rtl/cke_scheduler.sv
// cke_scheduler: multi-channel clock-enable scheduler.
// A shared prescaler divides clk by DIV = CLK_HZ/BASE_HZ into base_tick.
// Each channel derives cke[i] from base_tick with its own period and mode.
// Config writes are shadowed and committed on the next base_tick, so a
// channel never sees a partial update and never glitches mid-period.
//
// Optional feature macro: CKESCHED_ONESHOT_EN
//   defined     -> mode 11 is one-shot (single pulse, then the channel turns off)
//   not defined -> mode 11 is stored as off
//
// Config FSM
//   state  | meaning
//   IDLE   | cfg_ready=1, waiting for a write
//   PEND   | shadow holds a write, committed on the next base_tick
module cke_scheduler #(
  parameter int CLK_HZ   = 50000000,
  parameter int BASE_HZ  = 1000000,
  parameter int CHANNELS = 4,
  parameter int PW       = 16
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 cfg_valid,
  output logic                                                 cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]   cfg_ch,
  input  logic [PW-1:0]                                        cfg_period,
  input  logic [1:0]                                           cfg_mode,
  output logic                                                 base_tick,
  output logic [CHANNELS-1:0]                                  cke,
  output logic [CHANNELS-1:0]                                  busy
);

  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DIV = CLK_HZ / BASE_HZ;
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  localparam logic [1:0] M_OFF    = 2'b00;
  localparam logic [1:0] M_PULSE  = 2'b01;
  localparam logic [1:0] M_SQUARE = 2'b10;
  localparam logic [1:0] M_ONE    = 2'b11;

  if (DIV < 2) begin : g_div_check
    $error("cke_scheduler: CLK_HZ/BASE_HZ must be >= 2");
  end

  logic [DW-1:0]  div_q;
  logic           base_tick_q;
  logic [0:0]     state_q;
  logic [CHW-1:0] sh_ch;
  logic [PW-1:0]  sh_period;
  logic [1:0]     sh_mode;
  logic           commit;

  // Prescaler: count 0..DIV-1, register a one-cycle tick on the wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      base_tick_q <= 1'b0;
    end else if (div_q == DW'(DIV - 1)) begin
      div_q       <= '0;
      base_tick_q <= 1'b1;
    end else begin
      div_q       <= div_q + 1'b1;
      base_tick_q <= 1'b0;
    end
  end

  assign base_tick = base_tick_q;

  // Config FSM: capture a write into the shadow, release on the next tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sh_ch     <= '0;
      sh_period <= '0;
      sh_mode   <= M_OFF;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            sh_ch     <= cfg_ch;
            sh_period <= cfg_period;
`ifdef CKESCHED_ONESHOT_EN
            sh_mode   <= cfg_mode;
`else
            sh_mode   <= (cfg_mode == M_ONE) ? M_OFF : cfg_mode;
`endif
            state_q   <= S_PEND;
          end
        end
        default: begin
          if (base_tick_q) state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  // A tick in the accept cycle is seen while still IDLE, so it never commits.
  assign commit    = (state_q == S_PEND) && base_tick_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [PW-1:0] cnt_q;
    logic [PW-1:0] per_q;
    logic [1:0]    mode_q;
    logic          sq_q;
    logic          hit;
    logic          active;
    logic          wrap;
    logic [PW-1:0] cnt_nxt;
    logic          cke_i;

    assign hit     = commit && (sh_ch == CHW'(i));
    assign active  = (mode_q != M_OFF) && (per_q != '0);
    assign wrap    = (cnt_q == per_q - 1'b1);
    assign cnt_nxt = wrap ? '0 : cnt_q + 1'b1;

    // Channel state: commit restarts the phase, otherwise advance on ticks
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        per_q  <= '0;
        mode_q <= M_OFF;
        sq_q   <= 1'b0;
      end else if (hit) begin
        cnt_q  <= '0;
        per_q  <= sh_period;
        mode_q <= sh_mode;
        // cnt restarts at 0, which is inside the high half whenever period >= 2
        sq_q   <= (sh_mode == M_SQUARE) && ((sh_period >> 1) != '0);
      end else if (base_tick_q) begin
        if (active) begin
          cnt_q <= cnt_nxt;
          sq_q  <= (mode_q == M_SQUARE) && (cnt_nxt < (per_q >> 1));
`ifdef CKESCHED_ONESHOT_EN
          if ((mode_q == M_ONE) && wrap) mode_q <= M_OFF;
`endif
        end else begin
          cnt_q <= '0;
          sq_q  <= 1'b0;
        end
      end
    end

    // Output select; the committing channel is held low for its commit cycle
    always_comb begin
      cke_i = 1'b0;
      if (active && !hit) begin
        case (mode_q)
          M_PULSE:  cke_i = base_tick_q && wrap;
          M_SQUARE: cke_i = sq_q;
`ifdef CKESCHED_ONESHOT_EN
          M_ONE:    cke_i = base_tick_q && wrap;
`endif
          default:  cke_i = 1'b0;
        endcase
      end
    end

    assign cke[i]  = cke_i;
    assign busy[i] = active;
  end

endmodule

// File: tb/tb_cke_scheduler.sv
// Bench for cke_scheduler at CLK_HZ=100, BASE_HZ=10 (DIV=10), 4 channels, PW=8.
// The reference model counts clock edges and base ticks since each commit and
// derives every output from that tick count with modulo arithmetic.
// Honours CKESCHED_ONESHOT_EN the same way the design does.
module tb_cke_scheduler;

  localparam int DIV = 10;
  localparam int NCH = 4;
  localparam int PW  = 8;
`ifdef CKESCHED_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = '0;
  logic [PW-1:0]  cfg_period = '0;
  logic [1:0]     cfg_mode = '0;
  logic           base_tick;
  logic [NCH-1:0] cke;
  logic [NCH-1:0] busy;

  int total = 0;
  int bad   = 0;

  // reference model state
  int cyc;
  bit pend;
  int sh_ch, sh_per, sh_mode;
  int m_per  [NCH];
  int m_mode [NCH];
  int m_j    [NCH];

  cke_scheduler #(
    .CLK_HZ  (100),
    .BASE_HZ (10),
    .CHANNELS(NCH),
    .PW      (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_period(cfg_period),
    .cfg_mode  (cfg_mode),
    .base_tick (base_tick),
    .cke       (cke),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    cyc  = 0;
    pend = 1'b0;
    sh_ch = 0; sh_per = 0; sh_mode = 0;
    for (int i = 0; i < NCH; i++) begin
      m_per[i] = 0; m_mode[i] = 0; m_j[i] = 0;
    end
  endfunction

  // One clock: compare at negedge, advance model at posedge, leave inputs free at +1
  task automatic step();
    bit tk, cm, act, hit;
    logic [NCH-1:0] ek, eb;
    @(negedge clk);
    tk = (cyc > 0) && (cyc % DIV == 0);
    cm = pend && tk;
    ek = '0;
    eb = '0;
    for (int i = 0; i < NCH; i++) begin
      act = (m_mode[i] != 0) && (m_per[i] != 0);
      hit = cm && (sh_ch == i);
      eb[i] = act;
      if (act && !hit) begin
        case (m_mode[i])
          1: ek[i] = tk && ((m_j[i] % m_per[i]) == m_per[i] - 1);
          2: ek[i] = (m_j[i] % m_per[i]) < (m_per[i] / 2);
          3: ek[i] = tk && (m_j[i] == m_per[i] - 1);
          default: ek[i] = 1'b0;
        endcase
      end
    end
    chk("base_tick", base_tick, tk);
    chk("cke", cke, ek);
    chk("busy", busy, eb);
    chk("cfg_ready", cfg_ready, !pend);
    @(posedge clk);
    for (int i = 0; i < NCH; i++) begin
      act = (m_mode[i] != 0) && (m_per[i] != 0);
      if (cm && (sh_ch == i)) begin
        m_per[i]  = sh_per;
        m_mode[i] = sh_mode;
        m_j[i]    = 0;
      end else if (tk && act) begin
        if (m_mode[i] == 3 && m_j[i] == m_per[i] - 1) m_mode[i] = 0;
        m_j[i]++;
      end
    end
    if (cm) begin
      pend = 1'b0;
    end else if (!pend && cfg_valid) begin
      pend    = 1'b1;
      sh_ch   = int'(cfg_ch);
      sh_per  = int'(cfg_period);
      sh_mode = int'(cfg_mode);
      if (!ONESHOT && sh_mode == 3) sh_mode = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Hold a write on the port until the model says it was accepted
  task automatic wr(input int ch, input int per, input int md);
    bit acc;
    acc = 1'b0;
    cfg_valid  = 1'b1;
    cfg_ch     = ch[1:0];
    cfg_period = per[PW-1:0];
    cfg_mode   = md[1:0];
    for (int n = 0; n < 3 * DIV && !acc; n++) begin
      acc = !pend;
      step();
    end
    chk("wr_accept", acc, 1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", base_tick, 0);
    chk("rst_cke", cke, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rel_ready", cfg_ready, 1);

    // idle prescaler
    run(35);
    // pulse, period 3
    wr(0, 3, 1);
    run(100);
    // square, period 4 then the degenerate period 1
    wr(1, 4, 2);
    run(100);
    wr(1, 1, 2);
    run(40);
    // back-to-back writes: second waits for the first commit, ch1 keeps running
    wr(1, 4, 2);
    run(25);
    wr(0, 3, 1);
    wr(0, 5, 1);
    run(80);
    // mode 11 on ch2
    wr(2, 5, 3);
    run(80);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      cfg_valid  = ($urandom_range(0, 7) == 0);
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_period = ($urandom_range(0, 9) == 0) ? PW'($urandom_range(0, 255))
                                               : PW'($urandom_range(0, 6));
      cfg_mode   = 2'($urandom_range(0, 3));
      step();
    end
    cfg_valid = 1'b0;

    // reset with channels running and a write pending
    wr(0, 2, 1);
    wr(1, 4, 2);
    run(30);
    wr(3, 2, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tick", base_tick, 0);
    chk("mid_rst_cke", cke, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("mid_rel_ready", cfg_ready, 1);
    run(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
